// File: rtl/ysyx_25020047_pkg.sv
// Shared definitions for the LSU: inst_type bit positions, FSM state encoding
// and the decoded memory-operation type.
package ysyx_25020047_pkg;

    localparam int INST_LW  = 5;
    localparam int INST_LBU = 6;
    localparam int INST_SW  = 7;
    localparam int INST_SB  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_LW   = 3'd1,
        OP_LBU  = 3'd2,
        OP_SW   = 3'd3,
        OP_SB   = 3'd4
    } lsu_op_e;

    // Only an exact one-hot match is a memory op; anything else is a pass-through.
    function automatic lsu_op_e decode_op(input logic [63:0] inst_type);
        lsu_op_e op;
        op = OP_NONE;
        if (inst_type == (64'd1 << INST_LW))  op = OP_LW;
        if (inst_type == (64'd1 << INST_LBU)) op = OP_LBU;
        if (inst_type == (64'd1 << INST_SW))  op = OP_SW;
        if (inst_type == (64'd1 << INST_SB))  op = OP_SB;
        return op;
    endfunction

    function automatic logic is_store(input lsu_op_e op);
        return (op == OP_SW) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// Combinational byte-lane logic: store mask/data generation and load lane
// extraction with zero extension.
module ysyx_25020047_lsu_align
    import ysyx_25020047_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [1:0]  byte_sel,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [7:0] rlane [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rlane[gi]         = rdata[8*gi +: 8];
            // sb replicates the low byte so any lane selected by wmask sees it
            assign wdata[8*gi +: 8]  = (op == OP_SB) ? st_data[7:0] : st_data[8*gi +: 8];
            assign wmask[gi]         = (op == OP_SW) || ((op == OP_SB) && (byte_sel == 2'(gi)));
        end
    endgenerate

    assign ldata = (op == OP_LBU) ? {24'd0, rlane[byte_sel]} : rdata;

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit between EXU and WBU with a simple req/gnt/rvalid bus.
// Define YSYX_25020047_LSU_MISALIGN_CHK_EN to fault misaligned lw without a bus access.
module ysyx_25020047_lsu
    import ysyx_25020047_pkg::*;
#(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] inst_type,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] memdata,
    output logic        out_err,
    output logic        mem_req,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    lsu_state_e           state_reg, state_next;
    lsu_op_e              op_reg, op_next;
    logic [31:0]          addr_reg, addr_next;
    logic [31:0]          st_data_reg, st_data_next;
    logic [31:0]          memdata_reg, memdata_next;
    logic                 err_reg, err_next;
    logic [TIMEOUT_W-1:0] cnt_reg, cnt_next;

    lsu_op_e     op_in;
    logic        misalign;
    logic [3:0]  align_wmask;
    logic [31:0] align_wdata;
    logic [31:0] load_data;

    assign op_in = decode_op(inst_type);

`ifdef YSYX_25020047_LSU_MISALIGN_CHK_EN
    assign misalign = (op_in == OP_LW) && (addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    ysyx_25020047_lsu_align u_align (
        .op       (op_reg),
        .byte_sel (addr_reg[1:0]),
        .st_data  (st_data_reg),
        .rdata    (mem_rdata),
        .wmask    (align_wmask),
        .wdata    (align_wdata),
        .ldata    (load_data)
    );

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        addr_next    = addr_reg;
        st_data_next = st_data_reg;
        memdata_next = memdata_reg;
        err_next     = err_reg;
        cnt_next     = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    op_next      = op_in;
                    addr_next    = addr;
                    st_data_next = st_data;
                    memdata_next = 32'd0;
                    err_next     = misalign;
                    cnt_next     = '0;
                    if ((op_in == OP_NONE) || misalign) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    if (is_store(op_reg)) begin
                        state_next = ST_DONE;
                    end else if (mem_rvalid) begin
                        state_next   = ST_DONE;
                        memdata_next = load_data;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = '0;
                    end
                end
            end
            ST_WAIT: begin
                // A response on the limit cycle still wins over the timeout
                if (mem_rvalid) begin
                    state_next   = ST_DONE;
                    memdata_next = load_data;
                end else if (cnt_reg == CNT_MAX - 1'b1) begin
                    state_next   = ST_DONE;
                    cnt_next     = CNT_MAX;
                    memdata_next = 32'd0;
                    err_next     = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            op_reg      <= OP_NONE;
            addr_reg    <= 32'd0;
            st_data_reg <= 32'd0;
            memdata_reg <= 32'd0;
            err_reg     <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            addr_reg    <= addr_next;
            st_data_reg <= st_data_next;
            memdata_reg <= memdata_next;
            err_reg     <= err_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign memdata   = memdata_reg;
    assign out_err   = err_reg;
    assign mem_req   = (state_reg == ST_REQ);
    assign mem_wen   = mem_req && is_store(op_reg);
    assign mem_addr  = {addr_reg[31:2], 2'b00};
    assign mem_wdata = align_wdata;
    assign mem_wmask = mem_wen ? align_wmask : 4'b0000;

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Randomised bench for the LSU: each transaction is expanded into a per-cycle
// timeline of expected outputs, checked by one compare process at negedge.
module tb_ysyx_25020047_lsu;

    localparam int TW    = 4;
    localparam int LIMIT = (1 << TW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] inst_type = 64'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] st_data = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] memdata;
    logic        out_err;
    logic        mem_req;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    ysyx_25020047_lsu #(.TIMEOUT_W(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .inst_type  (inst_type),
        .addr       (addr),
        .st_data    (st_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .memdata    (memdata),
        .out_err    (out_err),
        .mem_req    (mem_req),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit        in_ready;
        bit        out_valid;
        bit        mem_req;
        bit        mem_wen;
        bit [3:0]  wmask;
        bit [31:0] maddr;
        bit [31:0] wdata;
        bit [31:0] memdata;
        bit        err;
        bit        chk_md;
        bit        chk_zero;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // statistics gathered by the compare process, used by literal checks
    int          acc_cyc = 0;
    int          lat = 0;
    int          req_cnt = 0;
    int          wait_cnt = 0;
    logic [31:0] last_md = 32'd0;
    logic        last_err = 1'b0;
    logic [3:0]  last_wmask = 4'd0;
    logic [31:0] last_wdata = 32'd0;
    logic        ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("in_ready", 32'(in_ready), 32'(e.in_ready));
            chk("out_valid", 32'(out_valid), 32'(e.out_valid));
            chk("mem_req", 32'(mem_req), 32'(e.mem_req));
            if (e.mem_req) begin
                chk("mem_addr", mem_addr, e.maddr);
                chk("mem_wen", 32'(mem_wen), 32'(e.mem_wen));
                if (e.mem_wen) begin
                    chk("mem_wmask", 32'(mem_wmask), 32'(e.wmask));
                    chk("mem_wdata", mem_wdata, e.wdata);
                end
            end
            if (e.out_valid) begin
                chk("out_err", 32'(out_err), 32'(e.err));
                if (e.chk_md) chk("memdata", memdata, e.memdata);
            end
            if (e.chk_zero) begin
                chk("rst_mem_wen", 32'(mem_wen), 32'd0);
                chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
                chk("rst_memdata", memdata, 32'd0);
                chk("rst_out_err", 32'(out_err), 32'd0);
            end
        end
        if (in_valid && in_ready) begin
            acc_cyc  = cyc;
            req_cnt  = 0;
            wait_cnt = 0;
        end else begin
            if (mem_req) begin
                req_cnt++;
                last_wmask = mem_wmask;
                last_wdata = mem_wdata;
            end
            if (!in_ready && !mem_req && !out_valid) wait_cnt++;
        end
        if (out_valid && !ov_prev) begin
            lat      = cyc - acc_cyc;
            last_md  = memdata;
            last_err = out_err;
        end
        ov_prev = out_valid;
    end

    function automatic int kind_of(input logic [63:0] it);
        case (it)
            64'h20:  return 1;
            64'h40:  return 2;
            64'h80:  return 3;
            64'h100: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic exp_t e_idle();
        exp_t e;
        e = '0;
        e.in_ready = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_req(input bit wen, input bit [3:0] m, input bit [31:0] a, input bit [31:0] wd);
        exp_t e;
        e = '0;
        e.mem_req = 1'b1;
        e.mem_wen = wen;
        e.wmask   = m;
        e.maddr   = a;
        e.wdata   = wd;
        return e;
    endfunction

    function automatic exp_t e_done(input bit [31:0] md, input bit err, input bit cmd);
        exp_t e;
        e = '0;
        e.out_valid = 1'b1;
        e.memdata   = md;
        e.err       = err;
        e.chk_md    = cmd;
        return e;
    endfunction

    function automatic logic [31:0] r32();
        return $urandom;
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic drive(input bit rst_v, input bit iv, input logic [63:0] it, input logic [31:0] a,
                         input logic [31:0] sd, input bit g, input bit rv, input logic [31:0] rd,
                         input bit ordy, input exp_t e);
        @(posedge clk);
        #1;
        rst        = rst_v;
        in_valid   = iv;
        inst_type  = it;
        addr       = a;
        st_data    = sd;
        mem_gnt    = g;
        mem_rvalid = rv;
        mem_rdata  = rd;
        out_ready  = ordy;
        exp_q.push_back(e);
    endtask

    // gd: REQ cycles before gnt; rd: WAIT cycles until rvalid (0 = with gnt)
    task automatic run_txn(input logic [63:0] it, input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rdat, input int gd, input int rd, input int hold);
        int          k;
        bit          ld, st, mis;
        logic [31:0] md, wd;
        logic [3:0]  msk;
        bit          err;
        int          nw;
        k   = kind_of(it);
        ld  = (k == 1) || (k == 2);
        st  = (k == 3) || (k == 4);
        mis = 1'b0;
`ifdef YSYX_25020047_LSU_MISALIGN_CHK_EN
        mis = (k == 1) && (a[1:0] != 2'b00);
`endif
        msk = (k == 3) ? 4'hF : ((k == 4) ? (4'b0001 << a[1:0]) : 4'h0);
        wd  = (k == 4) ? {4{sd[7:0]}} : sd;
        nw  = (rd < LIMIT) ? rd : LIMIT;
        if (k == 0 || st)  begin md = 32'd0; err = 1'b0; end
        else if (mis)      begin md = 32'd0; err = 1'b1; end
        else if (rd > LIMIT) begin md = 32'd0; err = 1'b1; end
        else if (k == 1)   begin md = rdat; err = 1'b0; end
        else               begin md = (rdat >> (8 * a[1:0])) & 32'hFF; err = 1'b0; end

        drive(0, 1, it, a, sd, rb(), rb(), r32(), rb(), e_idle());
        if ((ld || st) && !mis) begin
            for (int i = 0; i <= gd; i++) begin
                drive(0, rb(), r64(), r32(), r32(), i == gd, ld && i == gd && rd == 0,
                      (ld && i == gd && rd == 0) ? rdat : r32(), rb(),
                      e_req(st, msk, a & ~32'd3, wd));
            end
            if (ld && rd > 0) begin
                for (int j = 1; j <= nw; j++) begin
                    drive(0, rb(), r64(), r32(), r32(), rb(), j == rd, (j == rd) ? rdat : r32(),
                          rb(), '0);
                end
            end
        end
        for (int h = 0; h <= hold; h++) begin
            drive(0, rb(), r64(), r32(), r32(), rb(), rb(), r32(), h == hold, e_done(md, err, !st));
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, r64(), r32(), r32(), rb(), rb(), r32(), rb(), e_idle());
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        exp_t        ez;
        logic [63:0] it;
        int          sel, rdsel, rd;
        ez = e_idle();
        ez.chk_zero = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        drive(0, 0, 64'd0, 32'd0, 32'd0, 0, 0, 32'd0, 0, ez);
        idle_cycles(1);

        // non-memory instruction
        run_txn(64'h1, 32'h80000000, 32'h0, 32'h0, 0, 0, 0);
        settle();
        chk("nm_latency", 32'(lat), 32'd1);
        chk("nm_memdata", last_md, 32'd0);
        chk("nm_req_cycles", 32'(req_cnt), 32'd0);

        // lbu lane 2, gnt immediate, rvalid next cycle
        run_txn(64'h40, 32'h80000002, 32'h0, 32'hAABBCCDD, 0, 1, 0);
        settle();
        chk("lbu_latency", 32'(lat), 32'd3);
        chk("lbu_memdata", last_md, 32'h000000BB);
        chk("lbu_err", 32'(last_err), 32'd0);

        // sb lane 3 with gnt delayed two cycles
        run_txn(64'h100, 32'h80000003, 32'h12345678, 32'h0, 2, 0, 0);
        settle();
        chk("sb_req_cycles", 32'(req_cnt), 32'd3);
        chk("sb_wmask", 32'(last_wmask), 32'h8);
        chk("sb_wdata", last_wdata, 32'h78787878);

        // lw with no response: timeout
        run_txn(64'h20, 32'h80000100, 32'h0, 32'h0, 0, 100, 0);
        settle();
        chk("to_wait_cycles", 32'(wait_cnt), 32'(LIMIT));
        chk("to_err", 32'(last_err), 32'd1);
        chk("to_memdata", last_md, 32'd0);

        // lw response exactly on the limit cycle completes normally
        run_txn(64'h20, 32'h80000104, 32'h0, 32'hCAFEF00D, 0, LIMIT, 0);
        settle();
        chk("lim_err", 32'(last_err), 32'd0);
        chk("lim_memdata", last_md, 32'hCAFEF00D);

        // DONE held with out_ready low for 5 cycles
        run_txn(64'h20, 32'h80000200, 32'h0, 32'h01020304, 1, 2, 5);
        idle_cycles(1);

        // reset in WAIT, then a late rvalid must be ignored
        drive(0, 1, 64'h20, 32'h80000010, 32'd0, 0, 0, r32(), 1, e_idle());
        drive(0, 0, r64(), r32(), r32(), 1, 0, r32(), 1, e_req(0, 4'h0, 32'h80000010, 32'd0));
        drive(0, 0, r64(), r32(), r32(), 0, 0, r32(), 1, '0);
        drive(0, 0, r64(), r32(), r32(), 0, 0, r32(), 1, '0);
        drive(1, 0, r64(), r32(), r32(), 0, 0, r32(), 1, '0);
        drive(0, 0, r64(), r32(), r32(), 0, 1, 32'hDEADBEEF, 1, ez);
        idle_cycles(2);

`ifdef YSYX_25020047_LSU_MISALIGN_CHK_EN
        run_txn(64'h20, 32'h80000001, 32'h0, 32'h0, 0, 1, 0);
        settle();
        chk("mis_req_cycles", 32'(req_cnt), 32'd0);
        chk("mis_err", 32'(last_err), 32'd1);
`endif

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: it = 64'h20;
                1: it = 64'h40;
                2: it = 64'h80;
                3: it = 64'h100;
                4: it = 64'h1;
                default: it = r64() | 64'h60;
            endcase
            rdsel = $urandom_range(0, 9);
            if (rdsel < 7)       rd = $urandom_range(0, 3);
            else if (rdsel == 7) rd = LIMIT;
            else if (rdsel == 8) rd = LIMIT + 1;
            else                 rd = LIMIT - 1;
            run_txn(it, r32(), r32(), r32(), $urandom_range(0, 3), rd, $urandom_range(0, 3));
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(2);
        settle();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
